// File: rtl/pipe_share_arbiter.sv
// Round-robin sequencer sharing one fixed-latency pipelined logic unit among N_REQ requesters.
// Each issue carries its requester ID down a tag pipeline so the result can be routed back.
module pipe_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_in,
  input  logic [N_REQ*DATA_W-1:0]      data_in,
  input  logic                         pause_in,
  output logic [N_REQ-1:0]             grant_out,
  output logic                         pipe_valid_out,
  output logic [DATA_W-1:0]            pipe_data_out,
  input  logic                         pipe_result_in,
  output logic [N_REQ-1:0]             resp_valid_out,
  output logic                         resp_data_out,
  output logic [N_REQ-1:0]             busy_out,
  output logic [$clog2(N_REQ+1)-1:0]   inflight_out
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REQ+1);

  logic [N_REQ-1:0] elig;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  issue_id;
  logic             resp_any;

  logic [LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [LATENCY];

  // Search starts just after the most recent winner and wraps around.
  always_comb begin
    elig      = (rst || pause_in) ? '0 : (req_in & ~busy_out);
    grant_out = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_any && elig[(int'(last) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(last) + k) % N_REQ);
      end
    end
    if (grant_any) grant_out[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_out <= 1'b0;
      pipe_data_out  <= '0;
      issue_id       <= '0;
      last           <= ID_W'(N_REQ - 1);
    end else begin
      pipe_valid_out <= grant_any;
      if (grant_any) begin
        pipe_data_out <= data_in[grant_idx*DATA_W +: DATA_W];
        issue_id      <= grant_idx;
        last          <= grant_idx;
      end
    end
  end

  // Last tag stage lines up with pipe_result_in for the same operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= pipe_valid_out;
      tag_id[0]    <= issue_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    resp_valid_out = '0;
    resp_data_out  = 1'b0;
    resp_any       = tag_valid[LATENCY-1] && !rst;
    if (resp_any) begin
      resp_valid_out[tag_id[LATENCY-1]] = 1'b1;
      resp_data_out                     = pipe_result_in;
    end
  end

  // A response and a grant never target the same requester, so set/clear cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_out     <= '0;
      inflight_out <= '0;
    end else begin
      busy_out     <= (busy_out | grant_out) & ~resp_valid_out;
      inflight_out <= inflight_out + CNT_W'(grant_any) - CNT_W'(resp_any);
    end
  end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Scoreboard bench for pipe_share_arbiter: the bench plays the AND/OR datapath and
// predicts grants, issue registers and routed responses from a reference model.
module tb_pipe_share_arbiter;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 4;
  localparam int LATENCY = 3;
  localparam int CNT_W   = $clog2(N_REQ+1);
  localparam int DW_ALL  = N_REQ*DATA_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_in;
  logic [DW_ALL-1:0]   data_in;
  logic                pause_in;
  logic [N_REQ-1:0]    grant_out;
  logic                pipe_valid_out;
  logic [DATA_W-1:0]   pipe_data_out;
  logic                pipe_result_in;
  logic [N_REQ-1:0]    resp_valid_out;
  logic                resp_data_out;
  logic [N_REQ-1:0]    busy_out;
  logic [CNT_W-1:0]    inflight_out;

  pipe_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .pause_in(pause_in),
    .grant_out(grant_out), .pipe_valid_out(pipe_valid_out), .pipe_data_out(pipe_data_out),
    .pipe_result_in(pipe_result_in), .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out), .busy_out(busy_out), .inflight_out(inflight_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic dp_fn(input logic [DATA_W-1:0] x);
    return (&x[DATA_W-1:DATA_W/2]) | (&x[DATA_W/2-1:0]);
  endfunction

  // Datapath stand-in: registered input, LATENCY cycles to result, optional override.
  logic [LATENCY-1:0] dp_res = '0;
  logic               ovr_en = 1'b0;
  logic               ovr_val = 1'b0;
  always @(posedge clk) begin
    dp_res[0] <= dp_fn(pipe_data_out);
    for (int k = 1; k < LATENCY; k++) dp_res[k] <= dp_res[k-1];
  end
  assign pipe_result_in = ovr_en ? ovr_val : dp_res[LATENCY-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  typedef struct {
    int   id;
    logic data;
    int   due;
  } exp_t;
  exp_t sb_q[$];

  logic [N_REQ-1:0]  m_busy     = '0;
  int                m_last     = N_REQ - 1;
  logic              m_pv       = 1'b0;
  logic [DATA_W-1:0] m_pd       = '0;
  int                m_inflight = 0;

  logic [N_REQ-1:0]  elig, exp_grant, exp_resp;
  logic              exp_rdata, resp_due;
  int                gi;

  // Compare mid-cycle, then advance the model to what the next edge should commit.
  always @(negedge clk) begin
    if (cyc > 0) begin
      elig      = (rst || pause_in) ? '0 : (req_in & ~m_busy);
      exp_grant = '0;
      gi        = -1;
      for (int k = 0; k < N_REQ; k++)
        if (gi < 0 && elig[(m_last + 1 + k) % N_REQ]) gi = (m_last + 1 + k) % N_REQ;
      if (gi >= 0) exp_grant[gi] = 1'b1;

      resp_due  = !rst && sb_q.size() > 0 && sb_q[0].due == cyc;
      exp_resp  = '0;
      exp_rdata = 1'b0;
      if (resp_due) begin
        exp_resp[sb_q[0].id] = 1'b1;
        exp_rdata            = sb_q[0].data;
      end

      checkOutput("grant", 32'(grant_out), 32'(exp_grant));
      checkOutput("resp_valid", 32'(resp_valid_out), 32'(exp_resp));
      checkOutput("resp_data", 32'(resp_data_out), 32'(exp_rdata));
      checkOutput("pipe_valid", 32'(pipe_valid_out), 32'(m_pv));
      checkOutput("pipe_data", 32'(pipe_data_out), 32'(m_pd));
      checkOutput("busy", 32'(busy_out), 32'(m_busy));
      checkOutput("inflight", 32'(inflight_out), m_inflight);

      if (rst) begin
        m_busy     = '0;
        m_last     = N_REQ - 1;
        m_pv       = 1'b0;
        m_pd       = '0;
        m_inflight = 0;
        sb_q.delete();
      end else begin
        if (resp_due) begin
          m_busy[sb_q[0].id] = 1'b0;
          void'(sb_q.pop_front());
          m_inflight--;
        end
        m_pv = (gi >= 0);
        if (gi >= 0) begin
          m_busy[gi] = 1'b1;
          m_last     = gi;
          m_pd       = data_in[gi*DATA_W +: DATA_W];
          sb_q.push_back('{id: gi, data: dp_fn(data_in[gi*DATA_W +: DATA_W]), due: cyc + 1 + LATENCY});
          m_inflight++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [DW_ALL-1:0] data,
                               input logic pause, input logic rst_v, input int n);
    req_in   = req;
    data_in  = data;
    pause_in = pause;
    rst      = rst_v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [N_REQ-1:0]  r_req;
  logic [DW_ALL-1:0] r_data;
  logic              r_pause;

  initial begin
    applyStimulus('0, '0, 1'b0, 1'b1, 2);

    // single request, operand 1100 -> result 1
    applyStimulus(4'b0001, 16'h000C, 1'b0, 1'b0, 1);
    applyStimulus(4'b0000, 16'h000C, 1'b0, 1'b0, 8);

    // all requesters held; requester 0 comes back once its response retires
    applyStimulus(4'b1111, 16'hF3C9, 1'b0, 1'b0, 12);
    applyStimulus(4'b0000, 16'hF3C9, 1'b0, 1'b0, 8);

    // rotation after a grant to requester 2
    applyStimulus(4'b0100, 16'h0300, 1'b0, 1'b0, 1);
    applyStimulus(4'b1001, 16'hC00F, 1'b0, 1'b0, 1);
    applyStimulus(4'b0001, 16'hC00F, 1'b0, 1'b0, 1);
    applyStimulus(4'b0000, 16'hC00F, 1'b0, 1'b0, 8);

    // pause blocks grants but not responses of operations already in flight
    applyStimulus(4'b0011, 16'h00C3, 1'b1, 1'b0, 3);
    applyStimulus(4'b0011, 16'h00C3, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 16'h00C3, 1'b1, 1'b0, 6);
    applyStimulus(4'b0000, 16'h00C3, 1'b0, 1'b0, 4);

    // reset mid-flight; stray results afterwards must be ignored
    applyStimulus(4'b0011, 16'h00CC, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 16'h00CC, 1'b0, 1'b1, 1);
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    applyStimulus(4'b0000, 16'h00CC, 1'b0, 1'b0, 3);
    ovr_en  = 1'b0;
    applyStimulus(4'b0011, 16'h00CC, 1'b0, 1'b0, 1);
    applyStimulus(4'b0000, 16'h00CC, 1'b0, 1'b0, 8);

    repeat (80) begin
      r_req   = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      r_data  = DW_ALL'($urandom);
      r_pause = ($urandom_range(0, 7) == 0);
      applyStimulus(r_req, r_data, r_pause, 1'b0, 1);
    end
    applyStimulus(4'b0000, '0, 1'b0, 1'b0, 10);

    checkOutput("drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
